// File: rtl/chan_skid_slice_bank.sv
`default_nettype none
// chan_skid_slice_bank: CH independent ready/valid channels, each a wire (MODE=0)
// or a 2-entry registered skid slice with occupancy and synchronous flush (MODE=1). Rev 1.0
module chan_skid_slice_bank #(
   parameter int CH   = 4,
   parameter int W    = 32,
   parameter int MODE = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic [CH-1:0]   in_valid,
   output logic [CH-1:0]   in_ready,
   input  logic [CH*W-1:0] in_data,
   output logic [CH-1:0]   out_valid,
   input  logic [CH-1:0]   out_ready,
   output logic [CH*W-1:0] out_data,
   output logic [2*CH-1:0] occupancy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   generate
      if (MODE == 0) begin : g_bypass
         assign out_valid = in_valid;
         assign out_data  = in_data;
         assign in_ready  = out_ready;
         assign occupancy = '0;
      end else begin : g_skid
         for (genvar c = 0; c < CH; c++) begin : g_chan
            state_t       state_q;
            logic [W-1:0] main_q;
            logic [W-1:0] skid_q;
            logic         w_wr;
            logic         w_rd;

            // Ready is a function of held state and reset/flush only, so out_ready never reaches it
            assign in_ready[c]              = (state_q != S_TWO) && !reset && !flush;
            assign out_valid[c]             = (state_q != S_EMPTY);
            assign out_data[c*W +: W]       = main_q;
            assign occupancy[2*c +: 2]      = state_q;
            assign w_wr                     = in_valid[c] && in_ready[c];
            assign w_rd                     = out_valid[c] && out_ready[c];

            always_ff @(posedge clock) begin
               if (reset || flush) begin
                  state_q <= S_EMPTY;
               end else begin
                  case (state_q)
                     S_EMPTY: begin
                        if (w_wr) begin
                           state_q <= S_ONE;
                           main_q  <= in_data[c*W +: W];
                        end
                     end
                     S_ONE: begin
                        if (w_wr && !w_rd) begin
                           state_q <= S_TWO;
                           skid_q  <= in_data[c*W +: W];
                        end else if (w_wr && w_rd) begin
                           main_q  <= in_data[c*W +: W];
                        end else if (w_rd) begin
                           state_q <= S_EMPTY;
                        end
                     end
                     S_TWO: begin
                        if (w_rd) begin
                           state_q <= S_ONE;
                           main_q  <= skid_q;
                        end
                     end
                     default: state_q <= S_EMPTY;
                  endcase
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_chan_skid_slice_bank.sv
`default_nettype none
// Directed self-checking bench for chan_skid_slice_bank (MODE=1 slice bank and MODE=0 bypass).
module tb_chan_skid_slice_bank;
   localparam int CH = 4;
   localparam int W  = 32;

   logic            clk;
   logic            rst;
   logic            fl;
   logic [CH-1:0]   iv;
   logic [CH-1:0]   ird;
   logic [CH*W-1:0] id;
   logic [CH-1:0]   ov;
   logic [CH-1:0]   ordy;
   logic [CH*W-1:0] od;
   logic [2*CH-1:0] occ;
   logic [CH-1:0]   b_ird;
   logic [CH-1:0]   b_ov;
   logic [CH*W-1:0] b_od;
   logic [2*CH-1:0] b_occ;

   int errors = 0;
   int checks = 0;

   chan_skid_slice_bank #(.CH(CH), .W(W), .MODE(1)) u_dut (
      .clock(clk), .reset(rst), .flush(fl),
      .in_valid(iv), .in_ready(ird), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .occupancy(occ)
   );

   chan_skid_slice_bank #(.CH(CH), .W(W), .MODE(0)) u_byp (
      .clock(clk), .reset(rst), .flush(fl),
      .in_valid(iv), .in_ready(b_ird), .in_data(id),
      .out_valid(b_ov), .out_ready(ordy), .out_data(b_od), .occupancy(b_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; fl = 1'b0; iv = '0; ordy = '0; id = '0;
      tick(); tick();
      checks++; if (ov !== 4'h0) begin errors++; $display("FAIL reset_out_valid got=%h exp=0", ov); end
      checks++; if (occ !== 8'h00) begin errors++; $display("FAIL reset_occupancy got=%h exp=00", occ); end
      checks++; if (ird !== 4'h0) begin errors++; $display("FAIL reset_in_ready_low got=%h exp=0", ird); end
      rst = 1'b0;
      #1;
      checks++; if (ird !== 4'hF) begin errors++; $display("FAIL post_reset_in_ready got=%h exp=F", ird); end
   endtask

   task automatic test_single_beat();
      ordy = 4'hF; iv = 4'b0001; id[31:0] = 32'hDEADBEEF;
      #1;
      checks++; if (ird[0] !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", ird[0]); end
      tick();
      iv = 4'b0000;
      checks++; if (ov !== 4'b0001) begin errors++; $display("FAIL single_out_valid got=%h exp=1", ov); end
      checks++; if (od[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", od[31:0]); end
      checks++; if (occ !== 8'h01) begin errors++; $display("FAIL single_occ1 got=%h exp=01", occ); end
      tick();
      checks++; if (ov !== 4'b0000) begin errors++; $display("FAIL single_drain_valid got=%h exp=0", ov); end
      checks++; if (occ !== 8'h00) begin errors++; $display("FAIL single_occ0 got=%h exp=00", occ); end
   endtask

   task automatic test_skid();
      ordy = 4'b1101; iv = 4'b0010; id[63:32] = 32'h11;
      tick();
      id[63:32] = 32'h22;
      tick();
      iv = 4'b0000;
      #1;
      checks++; if (occ[3:2] !== 2'd2) begin errors++; $display("FAIL skid_occ2 got=%0d exp=2", occ[3:2]); end
      checks++; if (ird[1] !== 1'b0) begin errors++; $display("FAIL skid_in_ready_full got=%b exp=0", ird[1]); end
      checks++; if (ov[1] !== 1'b1 || od[63:32] !== 32'h11) begin errors++; $display("FAIL skid_head got=%b/%h exp=1/11", ov[1], od[63:32]); end
      ordy = 4'hF;
      tick();
      checks++; if (ov[1] !== 1'b1 || od[63:32] !== 32'h22) begin errors++; $display("FAIL skid_second got=%b/%h exp=1/22", ov[1], od[63:32]); end
      checks++; if (occ[3:2] !== 2'd1) begin errors++; $display("FAIL skid_occ1 got=%0d exp=1", occ[3:2]); end
      checks++; if (ird[1] !== 1'b1) begin errors++; $display("FAIL skid_ready_return got=%b exp=1", ird[1]); end
      tick();
      checks++; if (ov[1] !== 1'b0 || occ[3:2] !== 2'd0) begin errors++; $display("FAIL skid_drained got=%b/%0d exp=0/0", ov[1], occ[3:2]); end
   endtask

   task automatic test_stream();
      ordy = 4'hF; iv = 4'b0100;
      for (int k = 0; k < 100; k++) begin
         id[95:64] = k;
         #1;
         checks++; if (ird[2] !== 1'b1) begin errors++; $display("FAIL stream_ready beat=%0d got=%b exp=1", k, ird[2]); end
         tick();
         checks++;
         if (ov[2] !== 1'b1 || od[95:64] !== 32'(k) || occ[5:4] > 2'd1) begin
            errors++;
            $display("FAIL stream_beat beat=%0d got=%b/%0d/occ%0d exp=1/%0d/occ<=1", k, ov[2], od[95:64], occ[5:4], k);
         end
      end
      iv = 4'b0000;
      tick();
      checks++; if (ov[2] !== 1'b0 || occ[5:4] !== 2'd0) begin errors++; $display("FAIL stream_end got=%b/%0d exp=0/0", ov[2], occ[5:4]); end
   endtask

   task automatic test_random();
      logic [31:0] md0 [CH];
      logic [31:0] md1 [CH];
      int          mn  [CH];
      logic        wr, rd;
      rst = 1'b1; iv = '0; ordy = '0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < CH; c++) begin mn[c] = 0; md0[c] = '0; md1[c] = '0; end
      for (int t = 0; t < 3000; t++) begin
         iv   = 4'($urandom);
         ordy = 4'($urandom);
         id   = {$urandom, $urandom, $urandom, $urandom};
         #1;
         for (int c = 0; c < CH; c++) begin
            checks++;
            if (ird[c] !== (mn[c] < 2) || ov[c] !== (mn[c] != 0) || occ[2*c +: 2] !== 2'(mn[c])) begin
               errors++;
               $display("FAIL rand_state cyc=%0d ch=%0d got=rdy%b/vld%b/occ%0d exp=occ%0d", t, c, ird[c], ov[c], occ[2*c +: 2], mn[c]);
            end
            if (mn[c] != 0) begin
               checks++;
               if (od[c*W +: W] !== md0[c]) begin
                  errors++;
                  $display("FAIL rand_data cyc=%0d ch=%0d got=%h exp=%h", t, c, od[c*W +: W], md0[c]);
               end
            end
         end
         ordy = ~ordy;
         #1;
         for (int c = 0; c < CH; c++) begin
            checks++;
            if (ird[c] !== (mn[c] < 2)) begin
               errors++;
               $display("FAIL rand_ready_comb cyc=%0d ch=%0d got=%b exp=%b", t, c, ird[c], (mn[c] < 2));
            end
         end
         ordy = ~ordy;
         tick();
         for (int c = 0; c < CH; c++) begin
            rd = (mn[c] != 0) && ordy[c];
            wr = iv[c] && (mn[c] < 2);
            if (rd) begin md0[c] = md1[c]; mn[c]--; end
            if (wr) begin
               if (mn[c] == 0) md0[c] = id[c*W +: W];
               else            md1[c] = id[c*W +: W];
               mn[c]++;
            end
         end
      end
      iv = '0; ordy = 4'hF;
      tick(); tick(); tick();
      checks++; if (ov !== 4'h0 || occ !== 8'h00) begin errors++; $display("FAIL rand_drain got=%h/%h exp=0/00", ov, occ); end
   endtask

   task automatic test_flush(input bit use_reset);
      ordy = 4'b0111; iv = 4'b1000; id[127:96] = 32'hA;
      tick();
      id[127:96] = 32'hB;
      tick();
      checks++; if (occ[7:6] !== 2'd2) begin errors++; $display("FAIL flush_prefill rst=%0d got=%0d exp=2", use_reset, occ[7:6]); end
      id[127:96] = 32'hC; ordy = 4'hF;
      if (use_reset) rst = 1'b1; else fl = 1'b1;
      #1;
      checks++; if (ird !== 4'h0) begin errors++; $display("FAIL flush_ready_low rst=%0d got=%h exp=0", use_reset, ird); end
      tick();
      rst = 1'b0; fl = 1'b0; iv = 4'b0000;
      #1;
      checks++;
      if (occ !== 8'h00 || ov !== 4'h0 || ird !== 4'hF) begin
         errors++;
         $display("FAIL flush_after rst=%0d got=occ%h/vld%h/rdy%h exp=00/0/F", use_reset, occ, ov, ird);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (ov[3] !== 1'b0) begin errors++; $display("FAIL flush_ghost rst=%0d got=%h exp=0", use_reset, od[127:96]); end
      end
   endtask

   task automatic test_bypass();
      logic [3:0] iv_t [8];
      logic [3:0] or_t [8];
      iv_t = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h3, 4'hC, 4'h9, 4'h6};
      or_t = '{4'hF, 4'h0, 4'hA, 4'h5, 4'hC, 4'h3, 4'h6, 4'h9};
      for (int k = 0; k < 8; k++) begin
         iv   = iv_t[k];
         ordy = or_t[k];
         id   = {32'h1000_0000 + 32'(k), 32'hCAFE_0000 + 32'(k), 32'h5A5A_5A5A ^ 32'(k), 32'hFFFF_0000 | 32'(k)};
         rst  = k[0];
         fl   = k[1];
         #1;
         checks++;
         if (b_ov !== iv_t[k] || b_ird !== or_t[k] || b_occ !== 8'h00) begin
            errors++;
            $display("FAIL bypass_ctrl k=%0d got=vld%h/rdy%h/occ%h exp=%h/%h/00", k, b_ov, b_ird, b_occ, iv_t[k], or_t[k]);
         end
         checks++;
         if (b_od !== {32'h1000_0000 + 32'(k), 32'hCAFE_0000 + 32'(k), 32'h5A5A_5A5A ^ 32'(k), 32'hFFFF_0000 | 32'(k)}) begin
            errors++;
            $display("FAIL bypass_data k=%0d got=%h", k, b_od);
         end
         tick();
      end
      rst = 1'b0; fl = 1'b0; iv = '0;
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_skid();
      test_stream();
      test_flush(1'b0);
      test_flush(1'b1);
      test_random();
      test_bypass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
